grasspopper_keygen: RTL
=======================

Name: grasspopper_keygen

Overview:
- Round-key expansion unit for the GOST R 34.12-2015 (Kuznyechik) encoder pipeline.
- Sits directly upstream of the encoder stages. Takes a 256-bit master key and iteratively derives the 10 round keys K1..K10 using 32 Feistel rounds.
- Stores the keys in a local register file. The encoder stages and the final key-xor read them through an index-addressed port.

Parameters:
- NUM_RK, 10, number of round keys stored; fixed by the standard, not meant to be overridden.
- RK_IDX_W, 4, width of the round-key read index.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start_i  input  1  request expansion of key_i; sampled only in IDLE.
- key_i  input  256  master key; K1 = key_i[255:128], K2 = key_i[127:0]; sampled on the accepting edge only.
- busy_o  output  1  high while expansion is in progress.
- done_o  output  1  one-cycle pulse when all 10 keys are written.
- keys_valid_o  output  1  high when the register file holds a complete key set.
- rk_idx_i  input  RK_IDX_W  round-key read index, 0 = K1 .. 9 = K10.
- rk_o  output  128  round key at rk_idx_i; combinational read of the register file.

Behaviour:
- Reset (async, reset=1):
  - State goes to IDLE; round counter is 0.
  - All rk[0..9] are cleared to 0.
  - Outputs: busy_o=0, done_o=0, keys_valid_o=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start_i=1 at an edge:
  - Write rk[0]=key_i[255:128], rk[1]=key_i[127:0].
  - Load a1=key_i[255:128], a0=key_i[127:0]; load cnt=0.
  - keys_valid_o<=0, busy_o<=1; go to RUN.
- RUN, one Feistel round per edge:
  - a1 <= L(S(a1 ^ C[cnt])) ^ a0; a0 <= a1; cnt <= cnt+1.
  - C[i] is the standard constant C_(i+1) = L(Vec128(i+1)), i = 0..31.
  - When cnt[2:0]==7, the new a1/a0 are also written to rk[2+2j] and rk[3+2j], with j=cnt[4:3].
  - After the round with cnt==31: go to DONE.
- DONE, one cycle:
  - done_o=1, busy_o=0, keys_valid_o=1.
  - Next edge returns to IDLE; done_o drops to 0.
- Latency: start accepted at edge E0 → rounds at E1..E32 → done_o high in the cycle after E32. This is 33 cycles from start to done, combinational-L build.
- start_i outside IDLE is ignored; there is no queueing. key_i changes after acceptance have no effect.
- rk_idx_i ≥ 10 → rk_o = 128'h0.
- While busy, rk_o returns current register contents; these are partial for indices ≥ 2. Consumers must gate on keys_valid_o.
- The previous key set is overwritten progressively once a new start is accepted.
- Arithmetic:
  - S: bytewise 8-bit S-box (pi).
  - L: 16 iterations of R. Each R shifts the block one byte toward the least significant end; the new top byte is the GF(2^8) linear combination with coefficients 148,32,133,16,194,192,1,251,1,192,194,16,133,32,148,1.
  - GF(2^8) field polynomial: x^8+x^7+x^6+x+1 (0x1C3).
- Reset asserted mid-RUN aborts immediately. All keys are cleared; no done_o pulse is produced.

Optional Feature:
- Macro: GRASSPOPPER_KEYGEN_SERIAL_L_EN
- Defined (serial L, area-saving):
  - Each round takes 17 edges: 1 edge for X+S into a 128-bit work register, then 16 edges of single R steps. A 4-bit sub-counter tracks the R steps.
  - Feistel swap and rk writes happen on the 17th edge.
  - Start-to-done: 32*17+1 = 545 cycles.
  - busy_o, done_o and keys_valid_o semantics are unchanged.
- Undefined: L is fully combinational; 33-cycle latency as above.

Decomposition:
- Package grasspopper_pkg holds:
  - SBOX[256] table.
  - L coefficient array[16].
  - Constant table C[32].
  - gf_mul function for GF(2^8) multiplication.
  - NUM_RK and the FSM state typedef.
- One sub-module, grasspopper_lsx: combinational X (xor constant), S and L, plus a single-R-step output used by the serial build. The encoder stages can reuse it.

Test Plan:
- Standard vector: key=8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef, pulse start → done_o after 33 cycles. Expected keys:
  - rk[0]=8899aabbccddeeff0011223344556677
  - rk[1]=fedcba98765432100123456789abcdef
  - rk[2]=db31485315694343228d6aef8cc78c44
  - rk[3]=3d4553d8e9cfec6815ebadc40a9ffd04
  - rk[9]=72e9dd7416bcf45b755dbaa88e4a4043
- Constant check: force cnt=0 → C[0] applied equals 6ea276726c487ab85d27bd10dd849401. Sweep rk_idx_i=10..15 → rk_o=0.
- Start while busy: second start_i pulse at cycle 10 with a different key → ignored; results equal the first key's vector; single done_o pulse.
- Reset at cycle 20 of RUN → busy_o=0, keys_valid_o=0, all rk_o reads 0. Restart with the vector key → correct keys after 33 cycles.
- Back-to-back: start held high continuously → new expansion accepted on the edge after DONE. done_o pulses every 34 cycles; keys_valid_o drops on each acceptance.
- Serial build with GRASSPOPPER_KEYGEN_SERIAL_L_EN: same vector → identical rk[0..9]; done_o at cycle 545.

Source files
------------

// File: rtl/grasspopper_pkg.sv
// -----------------------------------------------------------------------------
// grasspopper_pkg
// Shared definitions for the Kuznyechik (GOST R 34.12-2015) key schedule and
// encoder datapath.
//   - NUM_RK / RK_IDX_W : round-key store geometry
//   - state_e           : key-expansion FSM states
//   - SBOX              : byte substitution table (pi)
//   - L_COEF            : linear-transform coefficients, L_COEF[j] multiplies
//                         byte j (byte 0 = least significant)
//   - C_TAB             : the 32 round constants C_(i+1) = L(Vec128(i+1)),
//                         generated at elaboration
//   - gf_mul / r_step / l_full / s_layer : arithmetic helpers
// -----------------------------------------------------------------------------
package grasspopper_pkg;

  localparam int NUM_RK   = 10;
  localparam int RK_IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
    8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
    8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
    8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
    8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
    8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
    8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
    8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
    8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
    8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
    8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
    8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
    8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
    8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
    8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
    8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
  };

  // Coefficient for the most significant byte comes first in the concatenation,
  // so L_COEF[j] pairs with byte j of the block.
  localparam logic [15:0][7:0] L_COEF = {
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  // GF(2^8) multiply modulo x^8+x^7+x^6+x+1 (low byte of 0x1C3 is 0xC3).
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      if (x[7]) x = {x[6:0], 1'b0} ^ 8'hC3;
      else      x = {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // One R step: shift one byte toward the LSB end, new top byte = l(block).
  function automatic logic [127:0] r_step(input logic [127:0] a);
    logic [7:0] acc;
    acc = 8'h00;
    for (int j = 0; j < 16; j++) acc = acc ^ gf_mul(a[8*j +: 8], L_COEF[j]);
    return {acc, a[127:8]};
  endfunction

  function automatic logic [127:0] l_full(input logic [127:0] a);
    logic [127:0] t;
    t = a;
    for (int n = 0; n < 16; n++) t = r_step(t);
    return t;
  endfunction

  function automatic logic [127:0] s_layer(input logic [127:0] v);
    logic [127:0] t;
    t = 128'd0;
    for (int b = 0; b < 16; b++) t[8*b +: 8] = SBOX[v[8*b +: 8]];
    return t;
  endfunction

  function automatic logic [31:0][127:0] gen_c_tab();
    logic [31:0][127:0] t;
    for (int i = 0; i < 32; i++) t[i] = l_full({120'd0, 8'(i) + 8'd1});
    return t;
  endfunction

  localparam logic [31:0][127:0] C_TAB = gen_c_tab();

endpackage

// File: rtl/grasspopper_lsx.sv
// -----------------------------------------------------------------------------
// grasspopper_lsx
// Combinational Kuznyechik round function pieces.
//   x_i   [127:0] : data block
//   k_i   [127:0] : key / constant xored into x_i
//   r_i   [127:0] : input to the single R step
//   xs_o  [127:0] : S(x_i ^ k_i)
//   lsx_o [127:0] : L(S(x_i ^ k_i))
//   r_o   [127:0] : R(r_i), one step of L for bit-serial use
// -----------------------------------------------------------------------------
module grasspopper_lsx
  import grasspopper_pkg::*;
(
  input  logic [127:0] x_i,
  input  logic [127:0] k_i,
  input  logic [127:0] r_i,
  output logic [127:0] xs_o,
  output logic [127:0] lsx_o,
  output logic [127:0] r_o
);

  assign xs_o  = s_layer(x_i ^ k_i);
  assign lsx_o = l_full(xs_o);
  assign r_o   = r_step(r_i);

endmodule

// File: rtl/grasspopper_keygen.sv
// -----------------------------------------------------------------------------
// grasspopper_keygen
// Kuznyechik round-key expansion: 256-bit master key -> K1..K10 via 32 Feistel
// rounds, stored in a local register file read by index.
//   clk, reset (async, active-high)
//   start_i, key_i[255:0]     : expansion request, sampled in IDLE only
//   busy_o, done_o            : expansion running / one-cycle completion pulse
//   keys_valid_o              : register file holds a complete key set
//   rk_idx_i[3:0], rk_o[127:0]: combinational round-key read, 0 = K1 .. 9 = K10,
//                               indices >= 10 read as zero
// Build option GRASSPOPPER_KEYGEN_SERIAL_L_EN: L is applied one R step per
// cycle (17 cycles per round); undefined gives one full round per cycle.
// -----------------------------------------------------------------------------
module grasspopper_keygen
  import grasspopper_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start_i,
  input  logic [255:0]        key_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                keys_valid_o,
  input  logic [RK_IDX_W-1:0] rk_idx_i,
  output logic [127:0]        rk_o
);

  state_e        state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [127:0]  a1_q, a1_d;
  logic [127:0]  a0_q, a0_d;
  logic [127:0]  rk_q [NUM_RK];
  logic [127:0]  rk_d [NUM_RK];
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;

  logic [127:0]  xs_s, lsx_s, r_s, r_in_s, f_s;
  logic          round_last_s;
  logic [3:0]    rk_wr_idx_s;
  logic          unused_s;

  grasspopper_lsx u_lsx (
    .x_i   (a1_q),
    .k_i   (C_TAB[cnt_q]),
    .r_i   (r_in_s),
    .xs_o  (xs_s),
    .lsx_o (lsx_s),
    .r_o   (r_s)
  );

`ifdef GRASSPOPPER_KEYGEN_SERIAL_L_EN
  // ph_q=0: next edge loads S(a1^C) into w_q; ph_q=1: R steps, sub_q counts them.
  logic          ph_q, ph_d;
  logic [3:0]    sub_q, sub_d;
  logic [127:0]  w_q, w_d;

  assign r_in_s       = w_q;
  assign f_s          = r_s ^ a0_q;
  assign round_last_s = ph_q & (sub_q == 4'd15);
  assign unused_s     = ^lsx_s;

  // Serial-L work register and step counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q  <= 1'b0;
      sub_q <= 4'd0;
      w_q   <= 128'd0;
    end else begin
      ph_q  <= ph_d;
      sub_q <= sub_d;
      w_q   <= w_d;
    end
  end
`else
  assign r_in_s       = xs_s;
  assign f_s          = lsx_s ^ a0_q;
  assign round_last_s = 1'b1;
  assign unused_s     = ^{xs_s, r_s};
`endif

  // Round j=cnt[4:3] produces K(3+2j), K(4+2j) -> rk[2+2j], rk[3+2j].
  assign rk_wr_idx_s = {1'b0, cnt_q[4:3], 1'b0} + 4'd2;

  // FSM, Feistel datapath and key-store registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      a1_q    <= 128'd0;
      a0_q    <= 128'd0;
      rk_q    <= '{default: 128'd0};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a1_q    <= a1_d;
      a0_q    <= a0_d;
      rk_q    <= rk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  // Next-state, round datapath and key-store write logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a1_d    = a1_q;
    a0_d    = a0_q;
    rk_d    = rk_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
`ifdef GRASSPOPPER_KEYGEN_SERIAL_L_EN
    ph_d    = ph_q;
    sub_d   = sub_q;
    w_d     = w_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rk_d[0] = key_i[255:128];
          rk_d[1] = key_i[127:0];
          a1_d    = key_i[255:128];
          a0_d    = key_i[127:0];
          cnt_d   = 5'd0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          state_d = ST_RUN;
`ifdef GRASSPOPPER_KEYGEN_SERIAL_L_EN
          ph_d    = 1'b0;
          sub_d   = 4'd0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
`ifdef GRASSPOPPER_KEYGEN_SERIAL_L_EN
        if (!ph_q) begin
          w_d   = xs_s;
          ph_d  = 1'b1;
          sub_d = 4'd0;
        end else begin
          w_d   = r_s;
          ph_d  = (sub_q != 4'd15);
          sub_d = sub_q + 4'd1;
        end
`endif
        if (round_last_s) begin
          a1_d  = f_s;
          a0_d  = a1_q;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q[2:0] == 3'd7) begin
            rk_d[rk_wr_idx_s]        = f_s;
            rk_d[rk_wr_idx_s + 4'd1] = a1_q;
          end else begin
            rk_d = rk_q;
          end
          if (cnt_q == 5'd31) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Index-addressed read of the key store.
  always_comb begin
    if (rk_idx_i < RK_IDX_W'(NUM_RK)) begin
      rk_o = rk_q[rk_idx_i];
    end else begin
      rk_o = 128'd0;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign keys_valid_o = valid_q;

endmodule
